// File: rtl/iir_sample_pacer.sv
// Input pacing buffer for an IIR SOS cascade: a small FIFO that re-emits
// buffered samples as single-cycle strobes spaced at least Ngap clocks apart.
module iir_sample_pacer #(
  parameter int          Ndint  = 3,
  parameter int          Ndfrac = 22,
  parameter int unsigned Ngap   = 6,
  parameter int unsigned Depth  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [Ndint-1:-Ndfrac]      s_data,
  output logic                        dv_out,
  output logic [Ndint-1:-Ndfrac]      d_out,
  output logic [$clog2(Depth):0]      level
);

  localparam int unsigned W  = Ndint + Ndfrac;
  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned LW = AW + 1;
  // Ngap=1 needs no countdown, but keep a 1-bit register so widths stay legal.
  localparam int unsigned GW = (Ngap > 1) ? $clog2(Ngap) : 1;

  typedef logic [W-1:0] word_t;

  word_t          mem_q [Depth];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]  level_q, level_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic           dv_q, dv_d;
  word_t          d_q, d_d;

  logic full;
  logic push;
  logic pop;

  // Ready comes from the registered occupancy only, never from s_valid.
  assign full    = (level_q == LW'(Depth));
  assign s_ready = !full && !rst;
  assign push    = s_valid && s_ready;
  // Pop decision uses pre-edge occupancy, so a push into an empty FIFO never falls through.
  assign pop     = (level_q != '0) && (gap_q == '0);

  assign dv_out = dv_q;
  assign d_out  = d_q;
  assign level  = level_q;

  // Next-state: pointers, occupancy, gap countdown and output strobe.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    gap_d    = gap_q;
    dv_d     = 1'b0;
    d_d      = d_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      dv_d     = 1'b1;
      d_d      = mem_q[rd_ptr_q];
      gap_d    = GW'(Ngap - 1);
    end else if (gap_q != '0) begin
      gap_d = gap_q - 1'b1;
    end

    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // State register with asynchronous reset; buffered data is discarded on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      gap_q    <= '0;
      dv_q     <= 1'b0;
      d_q      <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      gap_q    <= gap_d;
      dv_q     <= dv_d;
      d_q      <= d_d;
    end
  end

  // Sample storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s_data;
    end
  end

endmodule

// File: tb/tb_iir_sample_pacer.sv
// Bench for iir_sample_pacer: a Ngap=6 instance and a Ngap=1 instance, checked
// every cycle against a sample-log model plus directed literal expectations.
module tb_iir_sample_pacer;

  localparam int W     = 25;
  localparam int Depth = 16;
  localparam int LW    = 5;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           s_valid [2];
  logic           s_ready [2];
  logic [W-1:0]   s_data  [2];
  logic           dv_out  [2];
  logic [W-1:0]   d_out   [2];
  logic [LW-1:0]  level   [2];

  int vectors     = 0;
  int miscompares = 0;

  iir_sample_pacer #(.Ndint(3), .Ndfrac(22), .Ngap(6), .Depth(Depth)) u_dut0 (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid[0]),
    .s_ready (s_ready[0]),
    .s_data  (s_data[0]),
    .dv_out  (dv_out[0]),
    .d_out   (d_out[0]),
    .level   (level[0])
  );

  iir_sample_pacer #(.Ndint(3), .Ndfrac(22), .Ngap(1), .Depth(Depth)) u_dut1 (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid[1]),
    .s_ready (s_ready[1]),
    .s_data  (s_data[1]),
    .dv_out  (dv_out[1]),
    .d_out   (d_out[1]),
    .level   (level[1])
  );

  always #5 clk = ~clk;

  function automatic int gap_of(input int i);
    return (i == 0) ? 6 : 1;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s[%0d]: got %0h, expected %0h at %0t", name, idx, act, exp, $time);
    end
  endtask

  // Model: a log of every accepted sample; level is accepted minus emitted.
  logic [W-1:0] mlog [2][512];
  int           n_in     [2];
  int           n_out    [2];
  int           last_pop [2];
  logic         exp_dv   [2];
  logic [W-1:0] exp_d    [2];
  int           cyc = 0;
  int           strobes0 [$];
  int           strobes1 [$];

  // Model update at each edge from pre-edge inputs; cyc is the edge index.
  always @(posedge clk) begin
    bit acc;
    bit pop;
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        acc = s_valid[i] && ((n_in[i] - n_out[i]) < Depth);
        pop = ((n_in[i] - n_out[i]) > 0) && ((cyc - last_pop[i]) >= gap_of(i));
        if (pop) begin
          exp_d[i]    = mlog[i][n_out[i]];
          exp_dv[i]   = 1'b1;
          n_out[i]    = n_out[i] + 1;
          last_pop[i] = cyc;
        end else begin
          exp_dv[i] = 1'b0;
        end
        if (acc) begin
          mlog[i][n_in[i]] = s_data[i];
          n_in[i]          = n_in[i] + 1;
        end
      end
    end
    cyc = cyc + 1;
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        n_out[i]    = n_in[i];
        exp_dv[i]   = 1'b0;
        exp_d[i]    = '0;
        last_pop[i] = -1000;
      end
      chk("dv_out", i, 32'(dv_out[i]), 32'(exp_dv[i]));
      chk("d_out", i, 32'(d_out[i]), 32'(exp_d[i]));
      chk("level", i, 32'(level[i]), 32'(n_in[i] - n_out[i]));
      chk("s_ready", i, 32'(s_ready[i]), 32'(!rst && ((n_in[i] - n_out[i]) < Depth)));
    end
    if (dv_out[0] === 1'b1) strobes0.push_back(cyc - 1);
    if (dv_out[1] === 1'b1) strobes1.push_back(cyc - 1);
  end

  // Advance to 2 time units after the next rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Offer one sample; returns the edge index at which it was accepted.
  task automatic push(input int i, input logic [W-1:0] v, output int k);
    logic rdy;
    s_valid[i] = 1'b1;
    s_data[i]  = v;
    k = -1;
    for (int t = 0; t < 300; t++) begin
      rdy = s_ready[i];
      step();
      if (rdy) begin
        k = cyc - 1;
        break;
      end
    end
    s_valid[i] = 1'b0;
    if (k < 0) chk("push_timeout", i, 32'd1, 32'd0);
  endtask

  task automatic drain(input int i);
    for (int t = 0; t < 400; t++) begin
      if (level[i] == '0 && dv_out[i] == 1'b0) return;
      step();
    end
    chk("drain_timeout", i, 32'(level[i]), 32'd0);
  endtask

  initial begin
    int k;
    int k0;
    int s0;
    int lvmax;
    int offs [4];
    offs = '{1, 7, 13, 19};
    s_valid = '{1'b0, 1'b0};
    s_data  = '{'0, '0};
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #3;
    chk("ready_after_release", 0, 32'(s_ready[0]), 32'd1);
    step();

    // Single sample: strobe one edge after acceptance, value held afterwards.
    push(0, 25'h0123456, k);
    #3;
    chk("single_dv_k", 0, 32'(dv_out[0]), 32'd0);
    chk("single_level_k", 0, 32'(level[0]), 32'd1);
    step();
    #3;
    chk("single_dv_k1", 0, 32'(dv_out[0]), 32'd1);
    chk("single_d_k1", 0, 32'(d_out[0]), 32'h0123456);
    chk("single_level_k1", 0, 32'(level[0]), 32'd0);
    step();
    #3;
    chk("single_dv_k2", 0, 32'(dv_out[0]), 32'd0);
    chk("single_d_hold", 0, 32'(d_out[0]), 32'h0123456);
    step();

    // Burst of 4: strobes at k+1, k+7, k+13, k+19.
    repeat (8) step();
    s0 = strobes0.size();
    push(0, 25'h1000001, k0);
    push(0, 25'h1FFFFFF, k);
    push(0, 25'h0000000, k);
    push(0, 25'h0ABCDEF, k);
    repeat (24) step();
    chk("burst_count", 0, 32'(strobes0.size() - s0), 32'd4);
    for (int j = 0; j < 4; j++) begin
      if (s0 + j < strobes0.size()) chk("burst_edge", j, 32'(strobes0[s0 + j] - k0), 32'(offs[j]));
    end

    // Fill: 20 back-to-back offers must reach full and lose nothing.
    s0 = strobes0.size();
    lvmax = 0;
    for (int j = 0; j < 20; j++) begin
      push(0, 25'(32'h100 + j), k);
      if (int'(level[0]) > lvmax) lvmax = int'(level[0]);
    end
    chk("fill_level_max", 0, 32'(lvmax), 32'd16);
    drain(0);
    chk("fill_count", 0, 32'(strobes0.size() - s0), 32'd20);

    // Wrap: 40 incrementing values with random source gaps.
    s0 = strobes0.size();
    for (int j = 0; j < 40; j++) begin
      repeat ($urandom_range(0, 3)) step();
      push(0, 25'(j), k);
    end
    drain(0);
    chk("wrap_count", 0, 32'(strobes0.size() - s0), 32'd40);
    repeat (8) step();

    // Reset mid-burst with 5 samples buffered.
    for (int j = 0; j < 6; j++) push(0, 25'(32'h200 + j), k);
    chk("pre_reset_level", 0, 32'(level[0]), 32'd5);
    #1 rst = 1'b1;
    #1;
    chk("rst_dv", 0, 32'(dv_out[0]), 32'd0);
    chk("rst_level", 0, 32'(level[0]), 32'd0);
    chk("rst_ready", 0, 32'(s_ready[0]), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    s0 = strobes0.size();
    repeat (15) step();
    chk("post_reset_strobes", 0, 32'(strobes0.size() - s0), 32'd0);

    // Ngap=1: ten consecutive strobes starting one edge after the first accept.
    s0 = strobes1.size();
    lvmax = 0;
    for (int j = 1; j <= 10; j++) begin
      push(1, 25'(j), k);
      if (j == 1) k0 = k;
      if (int'(level[1]) > lvmax) lvmax = int'(level[1]);
    end
    repeat (4) step();
    chk("g1_count", 1, 32'(strobes1.size() - s0), 32'd10);
    for (int j = 0; j < 10; j++) begin
      if (s0 + j < strobes1.size()) chk("g1_edge", j, 32'(strobes1[s0 + j] - k0), 32'(j + 1));
    end
    chk("g1_level_max", 1, 32'(lvmax), 32'd1);
    chk("g1_last_d", 1, 32'(d_out[1]), 32'd10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
